// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding,
// iteration count and the write-back discard rule.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  // Register 0 of the integer file is hard-wired, so such results are dropped.
  function automatic logic is_discard(input logic [4:0] dreg, input logic dfp);
    return (dreg == 5'd0) && !dfp;
  endfunction

endpackage

// File: rtl/adder_n.sv
// Generic N-bit ripple adder with carry in/out.
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle mult/multu unit: sign-magnitude shift-add over ITER cycles,
// sign fix-up, then a held write-back slot released by wb_ack.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = mult_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       dest_reg,
  input  logic             dest_fp,
  output logic             reg_lock_mult,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_fp,
  input  logic             wb_ack
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic             neg_r;
  logic [4:0]       dreg_r;
  logic             dfp_r;

  logic             accept_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] final_s;
  logic             adder_cout_unused_s;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  adder_n #(.N(WIDTH)) u_acc_add (
    .a    (acc_r),
    .b    (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (adder_cout_unused_s)
  );

  // Operand magnitudes, accept decision, partial-product select and sign fix-up.
  always_comb begin
    accept_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s = start;
    end else if (state_r == DONE) begin
      accept_s = start & wb_ack;
    end else begin
      accept_s = 1'b0;
    end

    mag_a_s = op_a;
    if (is_signed && op_a[WIDTH-1]) begin
      mag_a_s = twos_neg(op_a);
    end else begin
      mag_a_s = op_a;
    end

    mag_b_s = op_b;
    if (is_signed && op_b[WIDTH-1]) begin
      mag_b_s = twos_neg(op_b);
    end else begin
      mag_b_s = op_b;
    end

    addend_s = ZERO;
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = ZERO;
    end

    final_s = acc_r;
    if (neg_r) begin
      final_s = twos_neg(acc_r);
    end else begin
      final_s = acc_r;
    end
  end

  // Control FSM, datapath registers and registered write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      mcand_r       <= ZERO;
      mplier_r      <= ZERO;
      acc_r         <= ZERO;
      neg_r         <= 1'b0;
      dreg_r        <= 5'd0;
      dfp_r         <= 1'b0;
      reg_lock_mult <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg        <= 5'd0;
      wb_data       <= ZERO;
      wb_fp         <= 1'b0;
    end else if (accept_s) begin
      // A DONE-state accept also retires the held result on this edge.
      mcand_r       <= mag_a_s;
      mplier_r      <= mag_b_s;
      neg_r         <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      dreg_r        <= dest_reg;
      dfp_r         <= dest_fp;
      acc_r         <= ZERO;
      cnt_r         <= {CNT_W{1'b0}};
      reg_lock_mult <= 1'b1;
      wb_valid      <= 1'b0;
      state_r       <= BUSY;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        BUSY: begin
          acc_r    <= sum_s;
          mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + C_ONE;
          if (cnt_r == LAST) begin
            state_r <= FIX;
          end else begin
            state_r <= BUSY;
          end
        end
        FIX: begin
          acc_r <= final_s;
          if (is_discard(dreg_r, dfp_r)) begin
            reg_lock_mult <= 1'b0;
            state_r       <= IDLE;
          end else begin
            wb_valid <= 1'b1;
            wb_data  <= final_s;
            wb_reg   <= dreg_r;
            wb_fp    <= dfp_r;
            state_r  <= DONE;
          end
        end
        DONE: begin
          if (wb_ack) begin
            wb_valid      <= 1'b0;
            reg_lock_mult <= 1'b0;
            state_r       <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed scenarios plus randomized
// operations compared against a plain-arithmetic product model.
module tb_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [4:0]   dest_reg = '0;
  logic         dest_fp = 1'b0;
  logic         wb_ack = 1'b0;
  logic         reg_lock_mult;
  logic         wb_valid;
  logic [4:0]   wb_reg;
  logic [W-1:0] wb_data;
  logic         wb_fp;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_data;
  logic [4:0]  exp_reg;
  logic        exp_fp;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .is_signed     (is_signed),
    .op_a          (op_a),
    .op_b          (op_b),
    .dest_reg      (dest_reg),
    .dest_fp       (dest_fp),
    .reg_lock_mult (reg_lock_mult),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .wb_fp         (wb_fp),
    .wb_ack        (wb_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic sgn);
    longint p;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'({32'd0, a}) * longint'({32'd0, b});
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lock"},  reg_lock_mult, 1'b0);
    check({tag, "_valid"}, wb_valid, 1'b0);
    check({tag, "_reg"},   wb_reg, 5'd0);
    check({tag, "_data"},  wb_data, 32'd0);
    check({tag, "_fp"},    wb_fp, 1'b0);
  endtask

  // Called just after a clock edge (cycle 0); returns sampled in cycle 34.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                input logic [4:0] dr, input logic fp, input logic ack_now,
                                input logic noise);
    logic discard;
    discard  = (dr == 5'd0) && !fp;
    exp_data = model_product(a, b, sgn);
    exp_reg  = dr;
    exp_fp   = fp;
    op_a = a; op_b = b; is_signed = sgn; dest_reg = dr; dest_fp = fp;
    start = 1'b1; wb_ack = ack_now;
    for (int c = 1; c <= 34; c++) begin
      tick();
      start = 1'b0; wb_ack = 1'b0;
      if (noise && c <= 32) begin
        start     = (c == 5) || ($urandom_range(0, 3) == 0);
        wb_ack    = 1'($urandom_range(0, 1));
        op_a      = $urandom; op_b = $urandom;
        dest_reg  = 5'($urandom); dest_fp = 1'($urandom);
        is_signed = 1'($urandom);
      end
      check($sformatf("lock_c%0d", c),  reg_lock_mult, (c < 34) || !discard);
      check($sformatf("valid_c%0d", c), wb_valid, (c == 34) && !discard);
    end
    if (!discard) begin
      check("wb_data", wb_data, exp_data);
      check("wb_reg",  wb_reg, exp_reg);
      check("wb_fp",   wb_fp, exp_fp);
    end
  endtask

  task automatic retire(input int hold);
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("hold_valid%0d", h), wb_valid, 1'b1);
      check($sformatf("hold_data%0d", h),  wb_data, exp_data);
      check($sformatf("hold_reg%0d", h),   wb_reg, exp_reg);
      check($sformatf("hold_lock%0d", h),  reg_lock_mult, 1'b1);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("retire_valid", wb_valid, 1'b0);
    check("retire_lock",  reg_lock_mult, 1'b0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unsigned 7*6
    issue_and_wait(32'h7, 32'h6, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    check("r36_data", wb_data, 32'h0000002A);
    retire(0);

    // Signed and unsigned -3*4 share the low word
    issue_and_wait(32'hFFFFFFFD, 32'h4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    check("r37_signed", wb_data, 32'hFFFFFFF4);
    retire(1);
    issue_and_wait(32'hFFFFFFFD, 32'h4, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    check("r37_unsigned", wb_data, 32'hFFFFFFF4);
    retire(0);

    // Most-negative operand, long hold
    issue_and_wait(32'h80000000, 32'hFFFFFFFF, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    check("r38_data", wb_data, 32'h80000000);
    retire(10);

    // Back-to-back: start with ack in DONE
    issue_and_wait(32'd1234, 32'd5678, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    retire(2);
    issue_and_wait(32'd11, 32'd13, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    issue_and_wait(32'd2, 32'd3, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    check("r39_data", wb_data, 32'd6);
    retire(0);

    // Abort in BUSY with reset
    op_a = 32'd100; op_b = 32'd200; is_signed = 1'b0; dest_reg = 5'd6; dest_fp = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      check($sformatf("post_abort_valid%0d", c), wb_valid, 1'b0);
    end

    // Start on the first edge after a reset pulse
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    issue_and_wait(32'hDEADBEEF, 32'h12345678, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1);
    retire(0);

    // Discarded destination
    issue_and_wait(32'd123, 32'd456, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("discard_lock", reg_lock_mult, 1'b0);
    check("discard_valid", wb_valid, 1'b0);

    // Randomized operations
    for (int i = 0; i < 10; i++) begin
      issue_and_wait($urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 1'b0, 1'b1);
      retire($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
